// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and
// the decoded-instruction handshake toward the decode stage.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/WAIT/HOLD sequencing with a single outstanding
// memory request; redirects mark the in-flight response for discard.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        discard_r;
    logic        req_r;
    logic        valid_r;
    logic [31:0] redirect_target_s;

    assign redirect_target_s = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.instr_valid = valid_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.opcode      = instr_r[6:0];

    // Fetch sequencer: reset beats redirect, redirect beats every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            // A request still in flight when reset hits WAIT must not be consumed later.
            discard_r  <= (state_r == WAIT);
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            instr_r    <= NOP_INSTR;
            instr_pc_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
            req_r      <= 1'b1;
        end else if (bus.redirect_valid) begin
            pc_r    <= redirect_target_s;
            valid_r <= 1'b0;
            case (state_r)
                FETCH: begin
                    discard_r <= 1'b1;
                    state_r   <= WAIT;
                    req_r     <= 1'b0;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        discard_r <= 1'b0;
                        state_r   <= FETCH;
                        req_r     <= 1'b1;
                    end else begin
                        discard_r <= 1'b1;
                        state_r   <= WAIT;
                        req_r     <= 1'b0;
                    end
                end
                HOLD: begin
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                end
                default: begin
                    discard_r <= 1'b0;
                    state_r   <= FETCH;
                    req_r     <= 1'b1;
                end
            endcase
        end else begin
            case (state_r)
                FETCH: begin
                    state_r <= WAIT;
                    req_r   <= 1'b0;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (discard_r) begin
                            discard_r <= 1'b0;
                            state_r   <= FETCH;
                            req_r     <= 1'b1;
                        end else begin
                            instr_r    <= bus.imem_rdata;
                            instr_pc_r <= pc_r;
                            pc_r       <= pc_r + 32'd4;
                            valid_r    <= 1'b1;
                            state_r    <= HOLD;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid_r <= 1'b0;
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    discard_r <= 1'b0;
                    valid_r   <= 1'b0;
                    state_r   <= FETCH;
                    req_r     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed reset/latency/redirect cases,
// a vector table of redirect scenarios and a randomized run against a
// program-order reference model.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_reset  = -100;
    int handshakes  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h00A0_2503;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- memory model: in-order responses, per-request latency
    typedef struct { int due; logic [31:0] addr; } resp_t;
    resp_t pend[$];
    int lat      = 1;
    bit lat_rand = 1'b0;
    int last_due = 0;

    always @(negedge clk) begin
        if (bus.imem_req === 1'b1 && reset === 1'b0) begin
            resp_t r;
            if (cyc - last_reset > 12) check("one_outstanding", 32'(pend.size()), 32'd0);
            r.due = cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.addr   = bus.imem_addr;
            pend.push_back(r);
        end
    end

    always begin
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
    end

    // ---------------- reference model: next program-order address
    logic [31:0] exp_pc = RESET_PC;
    bit started = 1'b0, redir_prev = 1'b0, reset_prev = 1'b0;
    int idle = 0;

    always @(negedge clk) begin
        if (started) begin
            if (reset_prev) begin
                check("rst_valid", 32'(bus.instr_valid), 32'd0);
                check("rst_instr", bus.instr, NOP_INSTR);
                check("rst_instr_pc", bus.instr_pc, 32'h0);
                check("rst_req", 32'(bus.imem_req), 32'd1);
            end else if (redir_prev) begin
                check("redirect_kills_valid", 32'(bus.instr_valid), 32'd0);
            end
            if (bus.imem_req === 1'b1) check("req_addr", bus.imem_addr, exp_pc);
            if (bus.instr_valid === 1'b1) begin
                check("valid_pc", bus.instr_pc, exp_pc);
                check("valid_word", bus.instr, mem_word(bus.instr_pc));
                check("opcode", {25'd0, bus.opcode}, {25'd0, bus.instr[6:0]});
                check("no_req_while_valid", 32'(bus.imem_req), 32'd0);
            end
            if (bus.imem_req !== 1'b1 && bus.instr_valid !== 1'b1 && reset === 1'b0) idle++;
            else idle = 0;
            if (idle > 15) begin
                check("liveness_idle", 32'(idle), 32'd15);
                idle = 0;
            end
        end
        reset_prev = reset;
        redir_prev = bus.redirect_valid;
        if (reset) begin
            started = 1'b1;
            exp_pc  = RESET_PC;
        end else begin
            if (bus.instr_valid === 1'b1 && bus.instr_ready) handshakes++;
            if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
            else if (bus.instr_valid === 1'b1 && bus.instr_ready) exp_pc = exp_pc + 32'd4;
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) return;
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) return;
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic accept();
        tick();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] tgt;
        int          latency;
        int          pre;
        int          stall;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl[5];
    logic [31:0] cap_pc, cap_instr;
    int t0, t1, hs0;

    initial begin
        tbl[0] = '{32'h0000_0102, 1, 1, 0, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'hFFFF_FFFC, 2, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_1003, 4, 2, 5, 32'h0000_1000, 32'h0000_1004};
        tbl[3] = '{32'h8000_0001, 3, 1, 2, 32'h8000_0000, 32'h8000_0004};
        tbl[4] = '{32'hFFFF_FFF8, 1, 3, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        last_reset = cyc;

        // first fetch after reset, 1-cycle memory
        @(negedge clk);
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, RESET_PC);
        wait_valid("first_word");
        check("first_instr", bus.instr, 32'h00A0_2503);
        check("first_instr_pc", bus.instr_pc, 32'h0);
        check("first_opcode", {25'd0, bus.opcode}, 32'h0000_0003);
        accept();
        @(negedge clk);
        check("second_req", 32'(bus.imem_req), 32'd1);
        check("second_addr", bus.imem_addr, 32'h0000_0004);

        // best-case throughput: one word every 3 cycles
        bus.instr_ready = 1'b1;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin
                if (t0 < 0) t0 = cyc;
                else t1 = cyc;
            end
        end
        check("throughput_period", 32'(t1 - t0), 32'd3);
        tick();
        bus.instr_ready = 1'b0;

        // latency 4 with a 5-cycle stall in HOLD
        lat = 4;
        wait_valid("stall_word");
        cap_pc    = bus.instr_pc;
        cap_instr = bus.instr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_pc", bus.instr_pc, cap_pc);
            check("stall_instr", bus.instr, cap_instr);
            check("stall_no_req", 32'(bus.imem_req), 32'd0);
        end
        accept();
        wait_req("after_stall");
        check("after_stall_addr", bus.imem_addr, cap_pc + 32'd4);

        // redirect scenarios from the vector table
        for (int k = 0; k < 5; k++) begin
            lat = tbl[k].latency;
            repeat (tbl[k].pre) tick();
            tick();
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tbl[k].tgt;
            tick();
            bus.redirect_valid = 1'b0;
            wait_valid("tbl_word0");
            check("tbl_pc0", bus.instr_pc, tbl[k].exp0);
            check("tbl_instr0", bus.instr, mem_word(tbl[k].exp0));
            for (int s = 0; s < tbl[k].stall; s++) begin
                @(negedge clk);
                check("tbl_stall_pc", bus.instr_pc, tbl[k].exp0);
            end
            accept();
            wait_valid("tbl_word1");
            check("tbl_pc1", bus.instr_pc, tbl[k].exp1);
            accept();
        end

        // redirect coincident with the response
        lat = 2;
        wait_req("coinc_req");
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        check("coinc_rvalid", 32'(bus.imem_rvalid), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        wait_valid("coinc_word");
        check("coinc_pc", bus.instr_pc, 32'h0000_0200);
        accept();

        // reset while waiting; stale response arrives after release
        lat = 3;
        wait_req("rstwait_req");
        tick();
        reset = 1'b1;
        lat = 1;
        tick();
        reset = 1'b0;
        last_reset = cyc;
        wait_valid("rstwait_word");
        check("rstwait_pc", bus.instr_pc, RESET_PC);
        check("rstwait_instr", bus.instr, mem_word(RESET_PC));
        accept();

        // randomized run
        lat_rand = 1'b1;
        hs0 = handshakes;
        for (int i = 0; i < 1500; i++) begin
            tick();
            bus.instr_ready    = ($urandom_range(9, 0) < 7);
            bus.redirect_valid = ($urandom_range(13, 0) == 0);
            if ($urandom_range(3, 0) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else bus.redirect_pc = $urandom;
        end
        tick();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        check("random_progress", 32'(handshakes - hs0 >= 50), 32'd1);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  one-cycle request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_rvalid  input  1  response strobe, one cycle, any latency >=1 cycle after the request.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 redirect_valid  input  1  branch/jump redirect strobe.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-011 instr_valid  output  1  instr/instr_pc/opcode hold a valid fetched word.
REQ-012 instr  output  32  fetched instruction, feeds decode and ImmGen.
REQ-013 instr_pc  output  32  address instr was fetched from.
REQ-014 opcode  output  7  instr[6:0], driven combinationally from the instr register.

Function
REQ-015 States SHALL be FETCH, WAIT and HOLD; at most one memory request outstanding.
REQ-016 FETCH: imem_req=1, imem_addr=pc for exactly one cycle; next state WAIT.
REQ-017 WAIT: imem_req=0; on imem_rvalid with discard=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32, wrap at 32'hFFFF_FFFC -> 0), next state HOLD.
REQ-018 HOLD: instr_valid=1, instr/instr_pc stable; on instr_ready next state FETCH; otherwise remain in HOLD indefinitely.
REQ-019 Best-case throughput SHALL be one instruction per 3 cycles at 1-cycle memory latency (FETCH, WAIT, HOLD).
REQ-020 Redirect SHALL take priority over all other events; pc<={redirect_pc[31:2],2'b00}; instr_valid SHALL be 0 from the next cycle.
REQ-021 Redirect in FETCH: the request at the old pc is still issued; discard<=1; next state WAIT.
REQ-022 Redirect in WAIT without imem_rvalid: discard<=1, remain in WAIT.
REQ-023 Redirect in WAIT with imem_rvalid, or imem_rvalid with discard=1: the response SHALL be dropped (instr unchanged), discard<=0, next state FETCH.
REQ-024 Redirect in HOLD: a coincident instr_ready completes the handshake; next state FETCH either way.
REQ-025 imem_rvalid outside WAIT SHALL be ignored.
REQ-026 Stalls (instr_ready=0) SHALL NOT issue new requests or alter pc.

Reset
REQ-027 While reset=1 at a rising edge: state<=FETCH, pc<=RESET_PC, discard<=0, instr<=32'h0000_0013 (NOP), instr_pc<=0, instr_valid<=0.
REQ-028 Reset SHALL override redirect and responses; a response arriving after reset for a pre-reset request SHALL be dropped (discard<=1 if reset is asserted in WAIT).
REQ-029 The first imem_req SHALL be asserted in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-030 Reset, 1-cycle memory returning 32'h00A02503 at 0 -> imem_addr=0, instr_valid=1 with instr=32'h00A02503, instr_pc=0, opcode=7'h03; next fetch at addr 4.
REQ-031 Memory latency 4, instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, no imem_req until ready, then fetch at pc+4.
REQ-032 Redirect to 32'h0000_0102 while in WAIT -> stale response dropped, next imem_addr=32'h0000_0100, instr_valid stays 0 until the new word arrives.
REQ-033 Redirect coincident with imem_rvalid -> word not presented; next request at the redirect target.
REQ-034 Redirect to 32'hFFFF_FFFC, two sequential fetches -> instr_pc=32'hFFFF_FFFC then 32'h0000_0000.
REQ-035 Reset asserted in WAIT, response returns 1 cycle after release -> response dropped, fetch restarts at RESET_PC.
